// File: rtl/btn_debounce.sv
// btn_debounce: synchronized, debounced push-button with press strobe, level and long-press flag
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw_i,
  output logic pulse_o,
  output logic level_o,
  output logic held_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic [1:0] state, state_n;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic sync, deb_done, accept;
  assign sync     = sync_ff[SYNC_STAGES-1];
  assign deb_done = db_cnt == DW'(DEBOUNCE_CYCLES - 1);
  assign accept   = state == PRESS_WAIT && state_n == PRESSED;
  assign level_o  = state == PRESSED || state == RELEASE_WAIT;
  assign held_o   = level_o && hold_cnt == HW'(HOLD_CYCLES);
  always_comb begin
    state_n = RELEASED;
    case (state)
      RELEASED:     state_n = sync ? PRESS_WAIT : RELEASED;
      PRESS_WAIT:   state_n = !sync ? RELEASED : deb_done ? PRESSED : PRESS_WAIT;
      PRESSED:      state_n = sync ? PRESSED : RELEASE_WAIT;
      RELEASE_WAIT: state_n = sync ? PRESSED : deb_done ? RELEASED : RELEASE_WAIT;
      default:      state_n = RELEASED;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff  <= '0;
      state    <= RELEASED;
      db_cnt   <= '0;
      hold_cnt <= '0;
      pulse_o  <= 1'b0;
    end else begin
      sync_ff  <= {sync_ff[SYNC_STAGES-2:0], button_raw_i};
      state    <= state_n;
      db_cnt   <= (state_n != state) ? '0 : (state == PRESS_WAIT || state == RELEASE_WAIT) ? db_cnt + 1'b1 : db_cnt;
      hold_cnt <= accept ? '0 : (state == PRESSED && hold_cnt != HW'(HOLD_CYCLES)) ? hold_cnt + 1'b1 : hold_cnt;
      pulse_o  <= accept;
    end
  end
endmodule
